sr_scan_ctrl: RTL and testbench
===============================

// Module: sr_scan_ctrl
// PURPOSE
//  Parametrised scan controller for a multiplexed shift-register display chain.
//  Steps through NUM_CH channels: drives o_muxsel, pulses o_srload, and waits out i_srbusy per channel.
//  Pulses o_latch once per frame and generates a programmable o_cnt_en tick.
//  Runs continuously or one frame per i_start. Sits between the data mux and the shift register/latch.
// PARAMETERS
//  NUM_CH      6   channels per frame, 2..16; CH_W = $clog2(NUM_CH) is a derived localparam
//  PRESCALE_W  8   width of prescaler counter and i_prescale_max
// PORTS
//  i_clk           in   1           system clock, rising edge
//  i_rst_n         in   1           asynchronous reset, active low
//  i_en            in   1           enable frame starts; sampled only in IDLE
//  i_mode          in   1           0 = continuous refresh, 1 = single-shot
//  i_start         in   1           single-shot trigger, level sampled in IDLE
//  i_prescale_max  in   PRESCALE_W  o_cnt_en period minus 1
//  i_srbusy        in   1           shift register busy; rises the cycle after o_srload
//  o_muxsel        out  CH_W        current channel index
//  o_srload        out  1           one-cycle load strobe to shift register
//  o_latch         out  1           one-cycle output-latch strobe, end of frame
//  o_cnt_en        out  1           one-cycle prescaler tick
//  o_busy          out  1           high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, i_rst_n=0)
//   - state=IDLE; all outputs 0; channel=0; scaler=0.
//   - Asserting reset mid-frame aborts the frame with no latch.
//  FSM, all outputs registered
//   - IDLE:  go to LOAD when i_en && (i_mode==0 || i_start) && !i_srbusy; else stay.
//   - LOAD:  o_srload=1 for this cycle only; -> GAP.
//   - GAP:   ignore i_srbusy (shift register is capturing); -> WAIT.
//   - WAIT:  hold while i_srbusy=1.
//            On i_srbusy=0: if channel==NUM_CH-1 -> LATCH; else channel+1 -> LOAD.
//   - LATCH: o_latch=1 for this cycle; channel <= 0; -> IDLE.
//  Channel index
//   - o_muxsel = channel; stable from LOAD through WAIT of that channel.
//   - Never exceeds NUM_CH-1, including when NUM_CH is not a power of 2.
//  Timing
//   - Busy high for B cycles gives load-to-load spacing of B+2 cycles.
//   - Continuous frame period is NUM_CH*(B+2)+2 cycles.
//     The IDLE pass costs 1 cycle, so i_en/i_mode are re-evaluated every frame.
//   - i_en and i_mode changes mid-frame take effect at the next IDLE.
//     The current frame always completes.
//   - i_start outside IDLE is ignored; it is not queued.
//   - i_srbusy stuck high stalls indefinitely in WAIT (no timeout); o_busy stays 1.
//  Prescaler, independent of the FSM
//   - scaler increments every cycle.
//   - When scaler >= i_prescale_max: o_cnt_en=1 next cycle and scaler <= 0.
//   - ">=" makes lowering i_prescale_max below scaler wrap at once; it never waits 2^PRESCALE_W.
//   - i_prescale_max=0 gives o_cnt_en high every cycle.
// STRUCTURE
//  Package sr_scan_pkg:
//   - state encodings S_IDLE, S_LOAD, S_GAP, S_WAIT, S_LATCH (3-bit).
//   - mode constants MODE_CONT=0, MODE_SINGLE=1.
//  Sub-module tick_prescaler #(W)
//   - ports (i_clk, i_rst_n, i_max, o_tick); reusable.
//  The FSM and channel counter live in sr_scan_ctrl.
// TESTING
//  1 Reset: hold i_rst_n=0 -> all outputs 0, o_muxsel=0.
//    Release with i_en=0 -> stays IDLE, o_busy=0.
//  2 Continuous, NUM_CH=6, busy high 4 cycles after each load
//    -> o_srload every 6 cycles with o_muxsel 0..5.
//    -> one o_latch per frame; next load 2 cycles after the latch; frame period 38.
//  3 Single-shot: i_mode=1, one-cycle i_start
//    -> exactly one frame, one o_latch, then IDLE.
//    -> a second i_start pulsed mid-frame produces no extra frame.
//  4 Prescaler: i_prescale_max=3 -> o_cnt_en every 4 cycles.
//    Set to 0 -> every cycle. Drop from 200 to 5 when scaler=100 -> tick next cycle.
//  5 Stall: i_srbusy stuck high on channel 2 for 50 cycles
//    -> o_muxsel=2 held, no o_srload or o_latch; resumes on release.
//  6 Reset mid-frame at channel 3 -> immediate zero outputs, no o_latch.
//    Next frame starts at channel 0.

Source files
------------

// File: rtl/sr_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed shift-register scan controller.
// State encoding, refresh-mode constants and the frame-start qualifier live here.
package sr_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_LATCH = 3'd4
  } scan_state_t;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // A frame may begin only while the shift register is idle, otherwise the
  // first load of the frame would collide with a transfer still in progress.
  function automatic logic frame_start_ok(
    input logic en,
    input logic mode,
    input logic start,
    input logic srbusy
  );
    return en && ((mode == MODE_CONT) || (mode == MODE_SINGLE && start)) && !srbusy;
  endfunction

endpackage

// File: rtl/sr_scan_ctrl_prescaler.sv
// Free-running tick generator: one-cycle o_tick every (i_max + 1) cycles.
// Wraps on ">=" so lowering i_max below the running count wraps immediately.
module tick_prescaler #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_max,
  output logic         o_tick
);

  logic [W-1:0] scaler_reg;
  logic         tick_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scaler_reg <= '0;
      tick_reg   <= 1'b0;
    end else if (scaler_reg >= i_max) begin
      scaler_reg <= '0;
      tick_reg   <= 1'b1;
    end else begin
      scaler_reg <= scaler_reg + 1'b1;
      tick_reg   <= 1'b0;
    end
  end

  assign o_tick = tick_reg;

endmodule

// File: rtl/sr_scan_ctrl.sv
// Scan controller for a multiplexed shift-register display chain: walks the
// channels, strobes each load, waits out the shift, latches once per frame.
module sr_scan_ctrl
  import sr_scan_pkg::*;
#(
  parameter int  NUM_CH     = 6,
  parameter int  PRESCALE_W = 8,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic                  i_start,
  input  logic [PRESCALE_W-1:0] i_prescale_max,
  input  logic                  i_srbusy,
  output logic [CH_W-1:0]       o_muxsel,
  output logic                  o_srload,
  output logic                  o_latch,
  output logic                  o_cnt_en,
  output logic                  o_busy
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  scan_state_t     state_reg;
  logic [CH_W-1:0] channel_reg;
  logic            srload_reg;
  logic            latch_reg;
  logic            busy_reg;

  // Strobes are set on the transition into their state so they line up with
  // that state's single cycle; busy tracks "next state is not IDLE".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= S_IDLE;
      channel_reg <= '0;
      srload_reg  <= 1'b0;
      latch_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      srload_reg <= 1'b0;
      latch_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (frame_start_ok(i_en, i_mode, i_start, i_srbusy)) begin
            state_reg  <= S_LOAD;
            srload_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        S_LOAD: state_reg <= S_GAP;
        // The shift register raises busy one cycle after the load strobe, so
        // busy is not trusted until WAIT.
        S_GAP:  state_reg <= S_WAIT;
        S_WAIT: begin
          if (!i_srbusy) begin
            if (channel_reg == LAST_CH) begin
              state_reg <= S_LATCH;
              latch_reg <= 1'b1;
            end else begin
              channel_reg <= channel_reg + 1'b1;
              state_reg   <= S_LOAD;
              srload_reg  <= 1'b1;
            end
          end
        end
        S_LATCH: begin
          channel_reg <= '0;
          state_reg   <= S_IDLE;
          busy_reg    <= 1'b0;
        end
        default: begin
          channel_reg <= '0;
          state_reg   <= S_IDLE;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign o_muxsel = channel_reg;
  assign o_srload = srload_reg;
  assign o_latch  = latch_reg;
  assign o_busy   = busy_reg;

  tick_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_max  (i_prescale_max),
    .o_tick (o_cnt_en)
  );

endmodule

// File: tb/tb_sr_scan_ctrl.sv
// Scoreboard bench for sr_scan_ctrl: stimulus predicts load/latch events and
// busy windows from frame timing arithmetic; a negedge monitor checks them.
module tb_sr_scan_ctrl;

  localparam int NUM_CH = 6;
  localparam int PW     = 8;
  localparam int CH_W   = $clog2(NUM_CH);

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_en = 1'b0;
  logic            i_mode = 1'b0;
  logic            i_start = 1'b0;
  logic [PW-1:0]   i_prescale_max = 8'd3;
  logic            i_srbusy = 1'b0;
  logic [CH_W-1:0] o_muxsel;
  logic            o_srload;
  logic            o_latch;
  logic            o_cnt_en;
  logic            o_busy;

  always #5 i_clk = ~i_clk;

  sr_scan_ctrl #(
    .NUM_CH    (NUM_CH),
    .PRESCALE_W(PW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_mode        (i_mode),
    .i_start       (i_start),
    .i_prescale_max(i_prescale_max),
    .i_srbusy      (i_srbusy),
    .o_muxsel      (o_muxsel),
    .o_srload      (o_srload),
    .o_latch       (o_latch),
    .o_cnt_en      (o_cnt_en),
    .o_busy        (o_busy)
  );

  typedef struct {bit is_latch; int ch; int cyc;} ev_t;
  typedef struct {int s; int e;} win_t;

  ev_t  evq[$];
  win_t wq[$];
  ev_t  ev_cur;
  int   bl[NUM_CH];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Shift-register model: busy rises the cycle after a load and stays high
  // for bl[channel] cycles.
  int pend_ch = 0;
  bit pend = 0;
  int left = 0;
  always @(negedge i_clk) begin
    if (i_rst_n && o_srload) begin
      pend    = 1;
      pend_ch = int'(o_muxsel);
    end
  end
  always @(posedge i_clk) begin
    #1;
    if (!i_rst_n) begin
      left = 0; pend = 0; i_srbusy = 1'b0;
    end else begin
      if (pend) begin
        left = (pend_ch < NUM_CH) ? bl[pend_ch] : 0;
        pend = 0;
      end
      i_srbusy = (left > 0);
      if (left > 0) left--;
    end
  end

  // Prescaler reference: cycles elapsed since the last wrap against the limit.
  int elapsed = 0;
  bit tick_m = 0;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      elapsed = 0; tick_m = 0;
    end else if (elapsed >= int'(i_prescale_max)) begin
      tick_m = 1; elapsed = 0;
    end else begin
      tick_m = 0; elapsed++;
    end
  end

  // Monitor
  int last_ch = 0;
  bit exp_busy;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("reset_outputs", 32'({o_srload, o_latch, o_cnt_en, o_busy, o_muxsel}), 32'd0);
      last_ch = 0;
    end else begin
      chk("cnt_en", 32'(o_cnt_en), 32'(tick_m));
      if (o_srload || o_latch) begin
        if (evq.size() == 0) begin
          chk("unexpected_strobe", 32'({o_srload, o_latch}), 32'd0);
        end else begin
          ev_cur = evq.pop_front();
          chk("strobe_kind", 32'({o_srload, o_latch}), ev_cur.is_latch ? 32'd1 : 32'd2);
          chk("strobe_cycle", 32'(cyc), 32'(ev_cur.cyc));
          if (!ev_cur.is_latch) begin
            chk("load_channel", 32'(o_muxsel), 32'(ev_cur.ch));
            last_ch = ev_cur.ch;
          end
        end
      end
      while (wq.size() > 0 && cyc > wq[0].e) void'(wq.pop_front());
      exp_busy = (wq.size() > 0) && (cyc >= wq[0].s);
      chk("busy", 32'(o_busy), 32'(exp_busy));
      chk("muxsel", 32'(o_muxsel), exp_busy ? 32'(last_ch) : 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge i_clk); #1; end
  endtask

  task automatic randomize_busy();
    foreach (bl[i]) bl[i] = int'($urandom_range(1, 6));
  endtask

  // Loads spaced by busy+2, latch one busy+2 after the last load.
  task automatic push_frame(input int s, output int l);
    int t = s;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      evq.push_back('{1'b0, ch, t});
      t += bl[ch] + 2;
    end
    evq.push_back('{1'b1, 0, t});
    wq.push_back('{s, t});
    l = t;
  endtask

  task automatic run_cont(input int frames);
    int s, l, s_last;
    l = 0;
    s = cyc + 1;
    s_last = s;
    i_mode = 1'b0;
    i_en = 1'b1;
    for (int f = 0; f < frames; f++) begin
      s_last = s;
      push_frame(s, l);
      s = l + 2;
    end
    wait_until(s_last);
    i_en = 1'b0;
    wait_until(l + 6);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int s, l, t, t3;
    foreach (bl[i]) bl[i] = 4;
    repeat (4) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick(6);

    run_cont(3);

    for (int r = 0; r < 4; r++) begin
      randomize_busy();
      i_prescale_max = PW'($urandom_range(0, 9));
      run_cont(1 + r % 2);
    end

    randomize_busy();
    i_mode = 1'b1;
    i_en = 1'b1;
    i_start = 1'b1;
    s = cyc + 1;
    push_frame(s, l);
    tick(1);
    i_start = 1'b0;
    wait_until(s + 10);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_until(l);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_until(l + 8);
    i_en = 1'b0;
    i_mode = 1'b0;

    i_prescale_max = 8'd3;
    tick(12);
    i_prescale_max = 8'd0;
    tick(10);
    i_prescale_max = 8'd200;
    for (int k = 0; k < 400 && elapsed != 100; k++) tick(1);
    i_prescale_max = 8'd5;
    tick(12);
    i_prescale_max = 8'd3;

    randomize_busy();
    bl[2] = 50;
    run_cont(1);

    randomize_busy();
    i_mode = 1'b0;
    i_en = 1'b1;
    s = cyc + 1;
    t = s;
    t3 = s;
    for (int ch = 0; ch <= 3; ch++) begin
      evq.push_back('{1'b0, ch, t});
      t3 = t;
      t += bl[ch] + 2;
    end
    wq.push_back('{s, t3 + 1});
    wait_until(t3 + 1);
    i_rst_n = 1'b0;
    i_en = 1'b0;
    evq.delete();
    wq.delete();
    tick(3);
    i_rst_n = 1'b1;
    tick(4);
    randomize_busy();
    run_cont(1);

    tick(5);
    chk("leftover_events", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
